// File: rtl/adat_frame_reader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : adat_frame_reader_pkg                                    |
// | Description : Shared constants, reader state encoding and the sample   |
// |               bit-reversal helper for the ADAT frame reader.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package adat_frame_reader_pkg;

    // Eight audio channels per ADAT frame, 24-bit samples.
    localparam int c_NUM_CHANNELS = 8;
    localparam int c_CHANNEL_BITS = 3;
    localparam int c_SAMPLE_WIDTH = 24;
    localparam int c_USER_BITS    = 4;

    // Reader sequencing states.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitFrame = 3'd1,
        StAddr      = 3'd2,
        StWaitData  = 3'd3,
        StOutput    = 3'd4
    } state_e;

    // The RAM stores bits in arrival order (bit 0 first), while the sample
    // is presented MSB first-received, so the word is mirrored.
    function automatic logic [c_SAMPLE_WIDTH-1:0] bit_reverse(
        input logic [c_SAMPLE_WIDTH-1:0] din
    );
        logic [c_SAMPLE_WIDTH-1:0] rev;
        for (int i = 0; i < c_SAMPLE_WIDTH; i++) begin
            rev[i] = din[c_SAMPLE_WIDTH-1-i];
        end
        return rev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adat_frame_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : adat_frame_reader                                        |
// | Description : Walks committed ADAT frames out of the circular sample   |
// |               RAM, one channel at a time, over a valid/ready sample    |
// |               interface, and flags skipped frames.                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module adat_frame_reader
    import adat_frame_reader_pkg::*;
#(
    parameter int CIRC_BUF_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       has_sync_i,
    input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
    input  logic [3:0]                 user_bits_i,
    output logic [CIRC_BUF_BITS+2:0]   ram_read_addr_o,
    input  logic [31:0]                ram_read_data_i,
    output logic [23:0]                sample_o,
    output logic [2:0]                 channel_o,
    output logic [3:0]                 frame_user_bits_o,
    output logic                       sample_valid_o,
    input  logic                       sample_ready_i,
    output logic                       frame_dropped_o
);

    state_e                      r_state;
    logic [CIRC_BUF_BITS-1:0]    r_cur_idx;
    logic [CIRC_BUF_BITS-1:0]    r_last_read_idx;
    logic                        r_first_seen;
    logic [c_CHANNEL_BITS-1:0]   r_channel;
    logic [c_USER_BITS-1:0]      r_user_bits;
    logic [CIRC_BUF_BITS+2:0]    r_ram_addr;
    logic [c_SAMPLE_WIDTH-1:0]   r_sample;
    logic                        r_sample_valid;
    logic                        r_frame_dropped;

    logic [CIRC_BUF_BITS-1:0]    w_idx_step;
    logic                        w_consecutive;
    logic                        w_new_frame;
    logic                        w_transfer;
    logic                        w_last_channel;
    logic                        w_unused;

    // Upper byte of the RAM word carries no sample bits.
    assign w_unused = ^ram_read_data_i[31:24];

    // Modular distance from the last fully read slot; wrap counts as consecutive.
    assign w_idx_step    = last_good_frame_idx_i - r_last_read_idx;
    assign w_consecutive = (w_idx_step == CIRC_BUF_BITS'(1));

    // Before any frame has been read the stored index is meaningless, so any
    // committed frame is taken as new once sync is present.
    assign w_new_frame    = has_sync_i &&
                            (!r_first_seen || (last_good_frame_idx_i != r_last_read_idx));
    assign w_transfer     = r_sample_valid && sample_ready_i;
    assign w_last_channel = (r_channel == c_CHANNEL_BITS'(c_NUM_CHANNELS - 1));

    // Reader sequencer: frame detection, RAM addressing, sample handshake.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state         <= StIdle;
            r_cur_idx       <= '0;
            r_last_read_idx <= '0;
            r_first_seen    <= 1'b0;
            r_channel       <= '0;
            r_user_bits     <= '0;
            r_ram_addr      <= '0;
            r_sample        <= '0;
            r_sample_valid  <= 1'b0;
            r_frame_dropped <= 1'b0;
        end else begin
            r_frame_dropped <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_first_seen <= 1'b0;
                    r_state      <= StWaitFrame;
                end
                StWaitFrame: begin
                    if (w_new_frame) begin
                        r_cur_idx       <= last_good_frame_idx_i;
                        r_user_bits     <= user_bits_i;
                        r_channel       <= '0;
                        r_frame_dropped <= r_first_seen && !w_consecutive;
                        r_state         <= StAddr;
                    end
                end
                StAddr: begin
                    r_ram_addr <= {r_cur_idx, r_channel};
                    r_state    <= StWaitData;
                end
                StWaitData: begin
                    r_sample       <= bit_reverse(ram_read_data_i[c_SAMPLE_WIDTH-1:0]);
                    r_sample_valid <= 1'b1;
                    r_state        <= StOutput;
                end
                StOutput: begin
                    // Sync loss is only acted on once the pending sample has gone out.
                    if (w_transfer) begin
                        r_sample_valid <= 1'b0;
                        if (!has_sync_i) begin
                            r_first_seen <= 1'b0;
                            r_state      <= StWaitFrame;
                        end else if (w_last_channel) begin
                            r_last_read_idx <= r_cur_idx;
                            r_first_seen    <= 1'b1;
                            r_state         <= StWaitFrame;
                        end else begin
                            r_channel <= r_channel + 1'b1;
                            r_state   <= StAddr;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ram_read_addr_o   = r_ram_addr;
    assign sample_o          = r_sample;
    assign channel_o         = r_channel;
    assign frame_user_bits_o = r_user_bits;
    assign sample_valid_o    = r_sample_valid;
    assign frame_dropped_o   = r_frame_dropped;

endmodule
`default_nettype wire

// File: tb/tb_adat_frame_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_adat_frame_reader                                     |
// | Description : Self-checking bench for adat_frame_reader with a         |
// |               behavioural frame/slot model and randomized traffic.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_adat_frame_reader;

    localparam int CIRC_BUF_BITS = 3;
    localparam int SLOTS         = 1 << CIRC_BUF_BITS;

    logic                      clk_i = 1'b0;
    logic                      reset_ni = 1'b0;
    logic                      has_sync_i = 1'b0;
    logic [CIRC_BUF_BITS-1:0]  last_good_frame_idx_i = '0;
    logic [3:0]                user_bits_i = '0;
    logic [CIRC_BUF_BITS+2:0]  ram_read_addr_o;
    logic [31:0]               ram_read_data_i;
    logic [23:0]               sample_o;
    logic [2:0]                channel_o;
    logic [3:0]                frame_user_bits_o;
    logic                      sample_valid_o;
    logic                      sample_ready_i = 1'b0;
    logic                      frame_dropped_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drop_count = 0;
    int drop_long = 0;
    logic prev_drop = 1'b0;

    // Sample RAM model: data follows the registered read address.
    logic [31:0] mem [SLOTS*8];
    assign ram_read_data_i = mem[ram_read_addr_o];

    // Reference model state: last fully read slot and whether one exists.
    int m_last = 0;
    bit m_first = 1'b0;

    // Captured transfers.
    logic [23:0] got_s   [8];
    logic [2:0]  got_ch  [8];
    logic [3:0]  got_ub  [8];
    int          got_cyc [8];

    adat_frame_reader #(.CIRC_BUF_BITS(CIRC_BUF_BITS)) dut (
        .clk_i                 (clk_i),
        .reset_ni              (reset_ni),
        .has_sync_i            (has_sync_i),
        .last_good_frame_idx_i (last_good_frame_idx_i),
        .user_bits_i           (user_bits_i),
        .ram_read_addr_o       (ram_read_addr_o),
        .ram_read_data_i       (ram_read_data_i),
        .sample_o              (sample_o),
        .channel_o             (channel_o),
        .frame_user_bits_o     (frame_user_bits_o),
        .sample_valid_o        (sample_valid_o),
        .sample_ready_i        (sample_ready_i),
        .frame_dropped_o       (frame_dropped_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Drop pulse monitor: counts pulses and pulses longer than one cycle.
    always @(negedge clk_i) begin
        if (frame_dropped_o) drop_count++;
        if (frame_dropped_o && prev_drop) drop_long++;
        prev_drop = frame_dropped_o;
    end

    // Expected sample: first-received bit (word bit 0) becomes the MSB.
    function automatic logic [23:0] exp_sample(input int slot, input int ch);
        logic [23:0] raw;
        logic [23:0] rev;
        raw = mem[slot * 8 + ch][23:0];
        rev = {<<{raw}};
        return rev;
    endfunction

    // A drop is any jump other than +1 modulo the slot count, once a frame was read.
    function automatic bit model_drop(input int slot);
        int d;
        d = ((slot - m_last) % SLOTS + SLOTS) % SLOTS;
        return m_first && (d != 1);
    endfunction

    task automatic commit(input int slot, input logic [3:0] ub);
        last_good_frame_idx_i = CIRC_BUF_BITS'(slot);
        user_bits_i           = ub;
        has_sync_i            = 1'b1;
    endtask

    // Collects up to n transfers; stops early if nothing arrives for 100 cycles.
    task automatic collect(input int n, input bit rnd, output int got);
        int idle;
        got  = 0;
        idle = 0;
        while (got < n && idle < 100) begin
            sample_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sample_valid_o && sample_ready_i) begin
                got_s[got]   = sample_o;
                got_ch[got]  = channel_o;
                got_ub[got]  = frame_user_bits_o;
                got_cyc[got] = cyc;
                got++;
                idle = 0;
            end else begin
                idle++;
            end
            @(negedge clk_i);
        end
        sample_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; has_sync_i = 1'b0; sample_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (sample_valid_o !== 1'b0 || frame_dropped_o !== 1'b0) begin
            failures++; $display("FAIL reset_flags: valid=%b drop=%b want 0 0", sample_valid_o, frame_dropped_o);
        end
        checks++;
        if (sample_o !== 24'h0 || channel_o !== 3'h0 || frame_user_bits_o !== 4'h0 || ram_read_addr_o !== '0) begin
            failures++; $display("FAIL reset_data: sample=%h ch=%0d ub=%h addr=%h want all 0",
                                 sample_o, channel_o, frame_user_bits_o, ram_read_addr_o);
        end
        reset_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        checks++;
        if (sample_valid_o !== 1'b0) begin
            failures++; $display("FAIL nosync_idle: valid=%b want 0", sample_valid_o);
        end
    endtask

    task automatic test_first_frame();
        int got;
        logic [3:0] ub;
        ub = 4'($urandom);
        mem[3 * 8] = 32'h0000_0001;
        reset_ni = 1'b0; has_sync_i = 1'b0; sample_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        commit(3, ub);
        reset_ni = 1'b1;
        drop_count = 0; drop_long = 0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (sample_valid_o !== 1'b0) begin
            failures++; $display("FAIL first_early_valid: valid=%b want 0", sample_valid_o);
        end
        @(negedge clk_i);
        checks++;
        if (sample_valid_o !== 1'b1 || sample_o !== 24'h800000 || channel_o !== 3'd0 || frame_user_bits_o !== ub) begin
            failures++; $display("FAIL first_latency: valid=%b sample=%h ch=%0d ub=%h want 1 800000 0 %h",
                                 sample_valid_o, sample_o, channel_o, frame_user_bits_o, ub);
        end
        collect(8, 1'b0, got);
        checks++;
        if (got !== 8) begin failures++; $display("FAIL first_count: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (got_s[i] !== exp_sample(3, i) || got_ch[i] !== 3'(i) || got_ub[i] !== ub) begin
                failures++; $display("FAIL first_xfer%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                     i, got_s[i], got_ch[i], got_ub[i], exp_sample(3, i), i, ub);
            end
        end
        for (int i = 1; i < got; i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] !== 3) begin
                failures++; $display("FAIL first_rate%0d: spacing %0d want 3", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        checks++;
        if (drop_count !== 0) begin failures++; $display("FAIL first_drop: pulses %0d want 0", drop_count); end
        m_last = 3; m_first = 1'b1;
    endtask

    task automatic test_backpressure();
        int got;
        logic [3:0] ub;
        logic [23:0] hold_s;
        logic [2:0] hold_ch;
        logic [3:0] hold_ub;
        ub = 4'($urandom);
        commit(4, ub);
        collect(4, 1'b0, got);
        checks++;
        if (got !== 4) begin failures++; $display("FAIL bp_head_count: got %0d want 4", got); end
        sample_ready_i = 1'b0;
        for (int k = 0; k < 20 && !sample_valid_o; k++) @(negedge clk_i);
        checks++;
        if (sample_valid_o !== 1'b1 || channel_o !== 3'd4) begin
            failures++; $display("FAIL bp_ch4_valid: valid=%b ch=%0d want 1 4", sample_valid_o, channel_o);
        end
        hold_s = sample_o; hold_ch = channel_o; hold_ub = frame_user_bits_o;
        repeat (10) begin
            @(negedge clk_i);
            checks++;
            if (sample_valid_o !== 1'b1 || sample_o !== hold_s || channel_o !== hold_ch || frame_user_bits_o !== hold_ub) begin
                failures++; $display("FAIL bp_hold: valid=%b sample=%h ch=%0d ub=%h want 1 %h %0d %h",
                                     sample_valid_o, sample_o, channel_o, frame_user_bits_o, hold_s, hold_ch, hold_ub);
            end
        end
        collect(4, 1'b0, got);
        checks++;
        if (got !== 4) begin failures++; $display("FAIL bp_tail_count: got %0d want 4", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (got_s[i] !== exp_sample(4, 4 + i) || got_ch[i] !== 3'(4 + i) || got_ub[i] !== ub) begin
                failures++; $display("FAIL bp_xfer%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                     4 + i, got_s[i], got_ch[i], got_ub[i], exp_sample(4, 4 + i), 4 + i, ub);
            end
        end
        m_last = 4; m_first = 1'b1;
    endtask

    task automatic test_drop();
        int seq [3];
        int got;
        bit exp_drop;
        logic [3:0] ub;
        seq = '{5, 7, 0};
        foreach (seq[f]) begin
            ub = 4'($urandom);
            exp_drop = model_drop(seq[f]);
            drop_count = 0; drop_long = 0;
            commit(seq[f], ub);
            collect(8, 1'b1, got);
            checks++;
            if (got !== 8) begin failures++; $display("FAIL drop_count_xfer slot %0d: got %0d want 8", seq[f], got); end
            for (int i = 0; i < got; i++) begin
                checks++;
                if (got_s[i] !== exp_sample(seq[f], i) || got_ch[i] !== 3'(i) || got_ub[i] !== ub) begin
                    failures++; $display("FAIL drop_xfer slot %0d ch%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                         seq[f], i, got_s[i], got_ch[i], got_ub[i], exp_sample(seq[f], i), i, ub);
                end
            end
            checks++;
            if (drop_count !== int'(exp_drop) || drop_long !== 0) begin
                failures++; $display("FAIL drop_pulse slot %0d: pulses=%0d long=%0d want %0d 0",
                                     seq[f], drop_count, drop_long, exp_drop);
            end
            m_last = seq[f]; m_first = 1'b1;
        end
    endtask

    task automatic test_mid_frame_commit();
        int got;
        bit exp_drop;
        logic [3:0] ub;
        logic [3:0] ub2;
        ub = 4'($urandom);
        ub2 = ~ub;
        exp_drop = model_drop(2);
        drop_count = 0;
        commit(2, ub);
        collect(3, 1'b0, got);
        commit(3, ub2);
        collect(5, 1'b0, got);
        checks++;
        if (got !== 5) begin failures++; $display("FAIL mid_count: got %0d want 5", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (got_s[i] !== exp_sample(2, 3 + i) || got_ch[i] !== 3'(3 + i) || got_ub[i] !== ub) begin
                failures++; $display("FAIL mid_xfer%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                     3 + i, got_s[i], got_ch[i], got_ub[i], exp_sample(2, 3 + i), 3 + i, ub);
            end
        end
        checks++;
        if (drop_count !== int'(exp_drop)) begin
            failures++; $display("FAIL mid_drop: pulses=%0d want %0d", drop_count, exp_drop);
        end
        m_last = 2; m_first = 1'b1;
        exp_drop = model_drop(3);
        drop_count = 0;
        collect(8, 1'b0, got);
        checks++;
        if (got !== 8) begin failures++; $display("FAIL next_count: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (got_s[i] !== exp_sample(3, i) || got_ch[i] !== 3'(i) || got_ub[i] !== ub2) begin
                failures++; $display("FAIL next_xfer%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                     i, got_s[i], got_ch[i], got_ub[i], exp_sample(3, i), i, ub2);
            end
        end
        checks++;
        if (drop_count !== int'(exp_drop)) begin
            failures++; $display("FAIL next_drop: pulses=%0d want %0d", drop_count, exp_drop);
        end
        m_last = 3; m_first = 1'b1;
    endtask

    task automatic test_sync_loss();
        int got;
        int extra;
        logic [3:0] ub;
        ub = 4'($urandom);
        commit(4, ub);
        collect(2, 1'b0, got);
        @(negedge clk_i);
        has_sync_i = 1'b0;
        collect(1, 1'b0, got);
        checks++;
        if (got !== 1 || got_ch[0] !== 3'd2 || got_s[0] !== exp_sample(4, 2)) begin
            failures++; $display("FAIL sync_ch2: got=%0d ch=%0d sample=%h want 1 2 %h",
                                 got, got_ch[0], got_s[0], exp_sample(4, 2));
        end
        extra = 0;
        sample_ready_i = 1'b1;
        repeat (12) begin
            @(negedge clk_i);
            if (sample_valid_o) extra++;
        end
        sample_ready_i = 1'b0;
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL sync_abort: %0d valid cycles want 0", extra); end
        m_first = 1'b0;
        ub = 4'($urandom);
        drop_count = 0;
        commit(6, ub);
        collect(8, 1'b1, got);
        checks++;
        if (got !== 8) begin failures++; $display("FAIL resync_count: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (got_s[i] !== exp_sample(6, i) || got_ch[i] !== 3'(i) || got_ub[i] !== ub) begin
                failures++; $display("FAIL resync_xfer%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                     i, got_s[i], got_ch[i], got_ub[i], exp_sample(6, i), i, ub);
            end
        end
        checks++;
        if (drop_count !== 0) begin failures++; $display("FAIL resync_drop: pulses=%0d want 0", drop_count); end
        m_last = 6; m_first = 1'b1;
    endtask

    task automatic test_random_frames();
        int got;
        int slot;
        int step;
        bit exp_drop;
        logic [3:0] ub;
        for (int f = 0; f < 16; f++) begin
            step = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, SLOTS - 1)) : 1;
            slot = (m_last + step) % SLOTS;
            for (int c = 0; c < 8; c++) mem[slot * 8 + c] = $urandom;
            ub = 4'($urandom);
            exp_drop = model_drop(slot);
            drop_count = 0; drop_long = 0;
            commit(slot, ub);
            collect(8, 1'b1, got);
            checks++;
            if (got !== 8) begin failures++; $display("FAIL rnd_count frame %0d: got %0d want 8", f, got); end
            for (int i = 0; i < got; i++) begin
                checks++;
                if (got_s[i] !== exp_sample(slot, i) || got_ch[i] !== 3'(i) || got_ub[i] !== ub) begin
                    failures++; $display("FAIL rnd_xfer f%0d ch%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                         f, i, got_s[i], got_ch[i], got_ub[i], exp_sample(slot, i), i, ub);
                end
            end
            checks++;
            if (drop_count !== int'(exp_drop) || drop_long !== 0) begin
                failures++; $display("FAIL rnd_drop frame %0d slot %0d: pulses=%0d long=%0d want %0d 0",
                                     f, slot, drop_count, drop_long, exp_drop);
            end
            m_last = slot; m_first = 1'b1;
        end
    endtask

    task automatic test_reset_mid_handshake();
        int got;
        int slot;
        logic [3:0] ub;
        slot = (m_last + 1) % SLOTS;
        commit(slot, 4'($urandom));
        collect(2, 1'b0, got);
        sample_ready_i = 1'b0;
        for (int k = 0; k < 20 && !sample_valid_o; k++) @(negedge clk_i);
        checks++;
        if (sample_valid_o !== 1'b1) begin failures++; $display("FAIL rst_hs_setup: valid=%b want 1", sample_valid_o); end
        reset_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (sample_valid_o !== 1'b0 || frame_dropped_o !== 1'b0) begin
            failures++; $display("FAIL rst_hs_flags: valid=%b drop=%b want 0 0", sample_valid_o, frame_dropped_o);
        end
        checks++;
        if (sample_o !== 24'h0 || channel_o !== 3'h0 || frame_user_bits_o !== 4'h0 || ram_read_addr_o !== '0) begin
            failures++; $display("FAIL rst_hs_data: sample=%h ch=%0d ub=%h addr=%h want all 0",
                                 sample_o, channel_o, frame_user_bits_o, ram_read_addr_o);
        end
        // The slot read before reset is offered again; it must be read afresh.
        m_first = 1'b0;
        ub = 4'($urandom);
        commit(m_last, ub);
        @(negedge clk_i);
        reset_ni = 1'b1;
        drop_count = 0;
        collect(8, 1'b1, got);
        checks++;
        if (got !== 8) begin failures++; $display("FAIL post_rst_count: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (got_s[i] !== exp_sample(m_last, i) || got_ch[i] !== 3'(i) || got_ub[i] !== ub) begin
                failures++; $display("FAIL post_rst_xfer%0d: sample=%h ch=%0d ub=%h want %h %0d %h",
                                     i, got_s[i], got_ch[i], got_ub[i], exp_sample(m_last, i), i, ub);
            end
        end
        checks++;
        if (drop_count !== 0) begin failures++; $display("FAIL post_rst_drop: pulses=%0d want 0", drop_count); end
    endtask

    initial begin
        for (int i = 0; i < SLOTS * 8; i++) mem[i] = $urandom;
        test_reset();
        test_first_frame();
        test_backpressure();
        test_drop();
        test_mid_frame_commit();
        test_sync_loss();
        test_random_frames();
        test_reset_mid_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
